pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Central stall/flush sequencer for the 5-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
//  Resolves load-use, HI/LO-busy, data-memory wait, taken branches and precise exceptions/ERET.
//  Drives every *_Stall/*_Flush input of the pipeline registers and the PC source select.
//  Tracks MDU occupancy with a countdown and exception-handler residency with a small FSM.
// PARAMETERS
//  MDU_LATENCY  32  cycles the multiply/divide unit stays busy after mdu_start (>=1)
//  EXC_VECTOR_SEL 2'b10  PC_Sel code for exception vector (fixed encoding, see ports)
// PORTS
//  clk            in   1  pipeline clock, rising edge
//  reset          in   1  asynchronous, active-high
//  ID_EX_MemRead  in   1  load in EX stage
//  ID_EX_rt       in   5  destination of that load
//  IF_ID_rs       in   5  rs of instruction in ID
//  IF_ID_rt       in   5  rt of instruction in ID
//  id_uses_rt     in   1  ID instruction reads rt
//  id_uses_hilo   in   1  ID instruction reads/writes HI/LO or is an MDU op
//  branch_taken   in   1  branch/jump resolved taken in ID
//  mdu_start      in   1  MDU op in EX this cycle (valid, not flushed)
//  mem_busy       in   1  data memory not ready for EX_MEM access
//  EX_MEM_ExcCode in   2  exception code of MEM-stage instr; 2'b00 = none
//  eret_id        in   1  ERET in ID
//  PC_Stall, IF_ID_Stall, ID_EX_Stall, EX_MEM_Stall  out 1 each  hold register
//  IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush, MEM_WB_Flush out 1 each  load bubble
//  PC_Sel         out  2  00 PC+4, 01 branch target, 10 exception vector, 11 EPC
//  EPC_we         out  1  capture EX_MEM_PCplus4-4 into EPC
//  exc_cause      out  2  registered cause of last taken exception
//  in_handler     out  1  FSM in HANDLER state
//  mdu_busy       out  1  mdu_cnt != 0
// BEHAVIOUR
//  Reset: state=RUN, mdu_cnt=0, exc_cause=0, in_handler=0, mdu_busy=0; with all inputs low
//   all stall/flush/EPC_we=0, PC_Sel=00. Reset mid-handler or mid-MDU returns to these values.
//  Control outputs combinational from state/mdu_cnt/inputs; state/counters update on clk rise.
//  Priority (highest first), one rule applied per cycle:
//  1 FREEZE: mem_busy=1 -> PC/IF_ID/ID_EX/EX_MEM_Stall=1, MEM_WB_Flush=1, PC_Sel=00; exception,
//    branch, ERET deferred (inputs held by stalled regs). No state change.
//  2 EXCEPTION: state=RUN and ExcCode!=0 -> IF_ID/ID_EX/EX_MEM_Flush=1, EPC_we=1, PC_Sel=10;
//    exc_cause<=ExcCode; state<=HANDLER. In HANDLER nonzero ExcCode ignored (no nesting).
//  3 ERET: state=HANDLER and eret_id -> PC_Sel=11, IF_ID_Flush=1; state<=RUN next edge.
//  4 HILO: mdu_cnt!=0 and id_uses_hilo -> PC_Stall, IF_ID_Stall, ID_EX_Flush=1.
//  5 LOAD-USE: ID_EX_MemRead, ID_EX_rt!=0, rt==IF_ID_rs or (id_uses_rt and rt==IF_ID_rt)
//    -> PC_Stall, IF_ID_Stall, ID_EX_Flush=1 (exactly 1 bubble).
//  6 BRANCH: branch_taken -> PC_Sel=01, IF_ID_Flush=1. Suppressed by 4/5 (re-resolved next cycle).
//  MDU counter: mdu_start and not FREEZE -> mdu_cnt<=MDU_LATENCY; else if mdu_cnt!=0 decrement
//   every cycle, including FREEZE and exception flush (MDU runs to completion).
//   mdu_cnt width = clog2(MDU_LATENCY+1); never wraps below 0.
//  HILO stall releases the cycle mdu_cnt reads 0; mdu_start while busy cannot occur (rule 4).
//  Stall and Flush never both asserted on the same register in one cycle.
// TESTING
//  1 lw $2 in EX, ID add uses $2 as rs -> 1 cycle PC/IF_ID_Stall+ID_EX_Flush; rt=$0 -> none.
//  2 mdu_start, MDU_LATENCY=4, mfhi in ID next cycle -> stall exactly 4 cycles, mdu_busy 4 cycles.
//  3 ExcCode=2'b01 in RUN -> 1 cycle flush IF_ID/ID_EX/EX_MEM, EPC_we, PC_Sel=10; exc_cause=01, in_handler=1.
//  4 ExcCode=2'b10 while HANDLER -> no flush/EPC_we; eret_id -> PC_Sel=11, IF_ID_Flush, in_handler=0 next cycle.
//  5 mem_busy 3 cycles with ExcCode=01 and branch_taken -> 3 freeze cycles, then exception sequence, branch dropped.
//  6 reset asserted mid-MDU and in HANDLER -> mdu_busy=0, in_handler=0, exc_cause=0 immediately.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and pipe_hazard_ctrl.
// The slave side is the controller; the master side is the pipeline, or a bench standing in for it.
interface pipe_hazard_ctrl_if;
    logic       ID_EX_MemRead;
    logic [4:0] ID_EX_rt;
    logic [4:0] IF_ID_rs;
    logic [4:0] IF_ID_rt;
    logic       id_uses_rt;
    logic       id_uses_hilo;
    logic       branch_taken;
    logic       mdu_start;
    logic       mem_busy;
    logic [1:0] EX_MEM_ExcCode;
    logic       eret_id;

    logic       PC_Stall;
    logic       IF_ID_Stall;
    logic       ID_EX_Stall;
    logic       EX_MEM_Stall;
    logic       IF_ID_Flush;
    logic       ID_EX_Flush;
    logic       EX_MEM_Flush;
    logic       MEM_WB_Flush;
    logic [1:0] PC_Sel;
    logic       EPC_we;
    logic [1:0] exc_cause;
    logic       in_handler;
    logic       mdu_busy;

    modport master (
        output ID_EX_MemRead, ID_EX_rt, IF_ID_rs, IF_ID_rt, id_uses_rt, id_uses_hilo,
               branch_taken, mdu_start, mem_busy, EX_MEM_ExcCode, eret_id,
        input  PC_Stall, IF_ID_Stall, ID_EX_Stall, EX_MEM_Stall, IF_ID_Flush, ID_EX_Flush,
               EX_MEM_Flush, MEM_WB_Flush, PC_Sel, EPC_we, exc_cause, in_handler, mdu_busy
    );

    modport slave (
        input  ID_EX_MemRead, ID_EX_rt, IF_ID_rs, IF_ID_rt, id_uses_rt, id_uses_hilo,
               branch_taken, mdu_start, mem_busy, EX_MEM_ExcCode, eret_id,
        output PC_Stall, IF_ID_Stall, ID_EX_Stall, EX_MEM_Stall, IF_ID_Flush, ID_EX_Flush,
               EX_MEM_Flush, MEM_WB_Flush, PC_Sel, EPC_we, exc_cause, in_handler, mdu_busy
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: freeze, exception/ERET, HI/LO, load-use, branch.
//   state   | meaning
//   RUN     | normal execution, exceptions accepted
//   HANDLER | inside exception handler, further exceptions ignored until ERET
module pipe_hazard_ctrl #(
    parameter int         MDU_LATENCY    = 32,
    parameter logic [1:0] EXC_VECTOR_SEL = 2'b10
) (
    input logic              clk,
    input logic              reset,
    pipe_hazard_ctrl_if.slave hz
);
    localparam int CW = $clog2(MDU_LATENCY + 1);
    localparam logic [1:0] SEL_PC4    = 2'b00;
    localparam logic [1:0] SEL_BRANCH = 2'b01;
    localparam logic [1:0] SEL_EPC    = 2'b11;

    typedef enum logic {RUN = 1'b0, HANDLER = 1'b1} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] mdu_cnt;
    logic [1:0]    cause;
    logic          exc_take;
    logic          load_use;
    logic          hilo_hit;

    assign load_use = hz.ID_EX_MemRead && (hz.ID_EX_rt != 5'd0) &&
                      ((hz.ID_EX_rt == hz.IF_ID_rs) ||
                       (hz.id_uses_rt && (hz.ID_EX_rt == hz.IF_ID_rt)));
    assign hilo_hit = (mdu_cnt != '0) && hz.id_uses_hilo;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= RUN;
            mdu_cnt <= '0;
            cause   <= 2'b00;
        end else begin
            state <= state_nx;
            if (exc_take)
                cause <= hz.EX_MEM_ExcCode;
            // The MDU keeps counting through freezes and flushes; only a fresh start reloads it.
            if (hz.mdu_start && !hz.mem_busy)
                mdu_cnt <= CW'(MDU_LATENCY);
            else if (mdu_cnt != '0)
                mdu_cnt <= mdu_cnt - CW'(1);
        end
    end

    always_comb begin
        state_nx        = state;
        exc_take        = 1'b0;
        hz.PC_Stall     = 1'b0;
        hz.IF_ID_Stall  = 1'b0;
        hz.ID_EX_Stall  = 1'b0;
        hz.EX_MEM_Stall = 1'b0;
        hz.IF_ID_Flush  = 1'b0;
        hz.ID_EX_Flush  = 1'b0;
        hz.EX_MEM_Flush = 1'b0;
        hz.MEM_WB_Flush = 1'b0;
        hz.PC_Sel       = SEL_PC4;
        hz.EPC_we       = 1'b0;

        if (hz.mem_busy) begin
            hz.PC_Stall     = 1'b1;
            hz.IF_ID_Stall  = 1'b1;
            hz.ID_EX_Stall  = 1'b1;
            hz.EX_MEM_Stall = 1'b1;
            hz.MEM_WB_Flush = 1'b1;
        end else if (state == RUN && hz.EX_MEM_ExcCode != 2'b00) begin
            exc_take        = 1'b1;
            hz.IF_ID_Flush  = 1'b1;
            hz.ID_EX_Flush  = 1'b1;
            hz.EX_MEM_Flush = 1'b1;
            hz.EPC_we       = 1'b1;
            hz.PC_Sel       = EXC_VECTOR_SEL;
            state_nx        = HANDLER;
        end else if (state == HANDLER && hz.eret_id) begin
            hz.PC_Sel      = SEL_EPC;
            hz.IF_ID_Flush = 1'b1;
            state_nx       = RUN;
        end else if (hilo_hit || load_use) begin
            // Branch in ID is held and re-resolved once the bubble clears.
            hz.PC_Stall    = 1'b1;
            hz.IF_ID_Stall = 1'b1;
            hz.ID_EX_Flush = 1'b1;
        end else if (hz.branch_taken) begin
            hz.PC_Sel      = SEL_BRANCH;
            hz.IF_ID_Flush = 1'b1;
        end
    end

    assign hz.exc_cause  = cause;
    assign hz.in_handler = (state == HANDLER);
    assign hz.mdu_busy   = (mdu_cnt != '0);
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus randomized traffic
// compared against a rule-level reference model.
module tb_pipe_hazard_ctrl;
    localparam int LAT = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if bus();
    pipe_hazard_ctrl #(.MDU_LATENCY(LAT)) dut (.clk(clk), .reset(reset), .hz(bus.slave));

    int n_cmp = 0;
    int n_err = 0;

    // reference model state
    bit       m_handler;
    bit [1:0] m_cause;
    int       m_mdu;

    logic [14:0] outs;
    assign outs = {bus.PC_Stall, bus.IF_ID_Stall, bus.ID_EX_Stall, bus.EX_MEM_Stall,
                   bus.IF_ID_Flush, bus.ID_EX_Flush, bus.EX_MEM_Flush, bus.MEM_WB_Flush,
                   bus.PC_Sel, bus.EPC_we, bus.exc_cause, bus.in_handler, bus.mdu_busy};

    function automatic logic [14:0] model_out();
        logic [3:0] st;
        logic [3:0] fl;
        logic [1:0] sel;
        logic       epc;
        bit         lu;
        st = 4'b0000; fl = 4'b0000; sel = 2'b00; epc = 1'b0;
        lu = bus.ID_EX_MemRead && bus.ID_EX_rt != 0 &&
             (bus.ID_EX_rt == bus.IF_ID_rs || (bus.id_uses_rt && bus.ID_EX_rt == bus.IF_ID_rt));
        if (bus.mem_busy) begin
            st = 4'b1111; fl = 4'b0001;
        end else if (!m_handler && bus.EX_MEM_ExcCode != 0) begin
            fl = 4'b1110; epc = 1'b1; sel = 2'b10;
        end else if (m_handler && bus.eret_id) begin
            fl = 4'b1000; sel = 2'b11;
        end else if ((m_mdu > 0 && bus.id_uses_hilo) || lu) begin
            st = 4'b1100; fl = 4'b0100;
        end else if (bus.branch_taken) begin
            fl = 4'b1000; sel = 2'b01;
        end
        return {st, fl, sel, epc, m_cause, m_handler, (m_mdu > 0)};
    endfunction

    task automatic model_reset();
        m_handler = 0; m_cause = 0; m_mdu = 0;
    endtask

    task automatic idle_inputs();
        bus.ID_EX_MemRead = 0; bus.ID_EX_rt = 0; bus.IF_ID_rs = 0; bus.IF_ID_rt = 0;
        bus.id_uses_rt = 0; bus.id_uses_hilo = 0; bus.branch_taken = 0; bus.mdu_start = 0;
        bus.mem_busy = 0; bus.EX_MEM_ExcCode = 0; bus.eret_id = 0;
    endtask

    // Advance the model across the coming rising edge, then return at the next falling edge.
    task automatic cycle_end();
        if (!bus.mem_busy) begin
            if (!m_handler && bus.EX_MEM_ExcCode != 0) begin
                m_handler = 1; m_cause = bus.EX_MEM_ExcCode;
            end else if (m_handler && bus.eret_id) begin
                m_handler = 0;
            end
        end
        if (bus.mdu_start && !bus.mem_busy) m_mdu = LAT;
        else if (m_mdu > 0) m_mdu = m_mdu - 1;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        #1;
        n_cmp++;
        if (outs !== 15'd0) begin
            n_err++; $display("FAIL reset_outputs: got %b want %b", outs, 15'd0);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_cmp++;
        if (outs !== model_out()) begin
            n_err++; $display("FAIL reset_release: got %b want %b", outs, model_out());
        end
        cycle_end();
    endtask

    task automatic test_load_use();
        bus.ID_EX_MemRead = 1; bus.ID_EX_rt = 5'd2; bus.IF_ID_rs = 5'd2; bus.IF_ID_rt = 5'd7;
        #1;
        n_cmp++;
        if ({bus.PC_Stall, bus.IF_ID_Stall, bus.ID_EX_Flush, bus.ID_EX_Stall} !== 4'b1110 ||
            outs !== model_out()) begin
            n_err++; $display("FAIL load_use_rs: got %b want %b", outs, model_out());
        end
        cycle_end();
        bus.ID_EX_MemRead = 0;
        #1;
        n_cmp++;
        if (outs !== 15'd0) begin
            n_err++; $display("FAIL load_use_one_bubble: got %b want %b", outs, 15'd0);
        end
        cycle_end();
        bus.ID_EX_MemRead = 1; bus.ID_EX_rt = 5'd0; bus.IF_ID_rs = 5'd0;
        #1;
        n_cmp++;
        if (outs !== 15'd0) begin
            n_err++; $display("FAIL load_use_r0: got %b want %b", outs, 15'd0);
        end
        cycle_end();
        bus.ID_EX_rt = 5'd5; bus.IF_ID_rs = 5'd1; bus.IF_ID_rt = 5'd5; bus.id_uses_rt = 1;
        #1;
        n_cmp++;
        if (bus.PC_Stall !== 1'b1 || outs !== model_out()) begin
            n_err++; $display("FAIL load_use_rt: got %b want %b", outs, model_out());
        end
        cycle_end();
        bus.id_uses_rt = 0;
        #1;
        n_cmp++;
        if (outs !== 15'd0) begin
            n_err++; $display("FAIL load_use_rt_unused: got %b want %b", outs, 15'd0);
        end
        cycle_end();
        idle_inputs();
    endtask

    task automatic test_mdu();
        int stalls = 0;
        int busy = 0;
        bus.mdu_start = 1;
        #1;
        n_cmp++;
        if (outs !== 15'd0) begin
            n_err++; $display("FAIL mdu_start_cycle: got %b want %b", outs, 15'd0);
        end
        cycle_end();
        bus.mdu_start = 0; bus.id_uses_hilo = 1;
        for (int i = 0; i < 8; i++) begin
            #1;
            n_cmp++;
            if (outs !== model_out()) begin
                n_err++; $display("FAIL mdu_cycle%0d: got %b want %b", i, outs, model_out());
            end
            if (bus.PC_Stall) stalls++;
            if (bus.mdu_busy) busy++;
            cycle_end();
        end
        n_cmp++;
        if (stalls !== LAT || busy !== LAT) begin
            n_err++; $display("FAIL mdu_stall_count: got %0d/%0d want %0d", stalls, busy, LAT);
        end
        idle_inputs();
    endtask

    task automatic test_exception();
        bus.EX_MEM_ExcCode = 2'b01;
        #1;
        n_cmp++;
        if ({bus.IF_ID_Flush, bus.ID_EX_Flush, bus.EX_MEM_Flush, bus.EPC_we, bus.PC_Sel} !== 6'b111110 ||
            outs !== model_out()) begin
            n_err++; $display("FAIL exc_take: got %b want %b", outs, model_out());
        end
        cycle_end();
        bus.EX_MEM_ExcCode = 2'b00;
        #1;
        n_cmp++;
        if (bus.exc_cause !== 2'b01 || bus.in_handler !== 1'b1) begin
            n_err++; $display("FAIL exc_state: got cause=%b handler=%b want 01/1", bus.exc_cause, bus.in_handler);
        end
        cycle_end();
    endtask

    task automatic test_eret();
        bus.EX_MEM_ExcCode = 2'b10;
        #1;
        n_cmp++;
        if (bus.EPC_we !== 1'b0 || bus.IF_ID_Flush !== 1'b0 || outs !== model_out()) begin
            n_err++; $display("FAIL exc_nested: got %b want %b", outs, model_out());
        end
        cycle_end();
        bus.EX_MEM_ExcCode = 2'b00; bus.eret_id = 1;
        #1;
        n_cmp++;
        if (bus.PC_Sel !== 2'b11 || bus.IF_ID_Flush !== 1'b1 || outs !== model_out()) begin
            n_err++; $display("FAIL eret: got %b want %b", outs, model_out());
        end
        cycle_end();
        bus.eret_id = 0;
        #1;
        n_cmp++;
        if (bus.in_handler !== 1'b0 || bus.exc_cause !== 2'b01) begin
            n_err++; $display("FAIL eret_exit: got handler=%b cause=%b want 0/01", bus.in_handler, bus.exc_cause);
        end
        cycle_end();
    endtask

    task automatic test_freeze();
        bus.mem_busy = 1; bus.EX_MEM_ExcCode = 2'b01; bus.branch_taken = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++;
            if (outs !== {4'b1111, 4'b0001, 2'b00, 1'b0, m_cause, 1'b0, 1'b0}) begin
                n_err++; $display("FAIL freeze%0d: got %b want %b", i, outs, model_out());
            end
            cycle_end();
        end
        bus.mem_busy = 0;
        #1;
        n_cmp++;
        if (bus.PC_Sel !== 2'b10 || bus.EPC_we !== 1'b1 || outs !== model_out()) begin
            n_err++; $display("FAIL freeze_then_exc: got %b want %b", outs, model_out());
        end
        cycle_end();
        bus.EX_MEM_ExcCode = 0; bus.branch_taken = 0; bus.eret_id = 1;
        #1;
        n_cmp++;
        if (bus.in_handler !== 1'b1 || outs !== model_out()) begin
            n_err++; $display("FAIL freeze_handler: got %b want %b", outs, model_out());
        end
        cycle_end();
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        bus.mdu_start = 1; bus.EX_MEM_ExcCode = 2'b11;
        cycle_end();
        idle_inputs();
        #1;
        n_cmp++;
        if (bus.mdu_busy !== 1'b1 || bus.in_handler !== 1'b1 || bus.exc_cause !== 2'b11) begin
            n_err++; $display("FAIL pre_reset_state: got %b want %b", outs, model_out());
        end
        #1;
        reset = 1'b1;
        model_reset();
        #1;
        n_cmp++;
        if (bus.mdu_busy !== 1'b0 || bus.in_handler !== 1'b0 || bus.exc_cause !== 2'b00) begin
            n_err++; $display("FAIL async_reset: got %b want %b", outs, 15'd0);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            bus.ID_EX_MemRead  = ($urandom_range(0, 1) == 1);
            bus.ID_EX_rt       = 5'($urandom_range(0, 3));
            bus.IF_ID_rs       = 5'($urandom_range(0, 3));
            bus.IF_ID_rt       = 5'($urandom_range(0, 3));
            bus.id_uses_rt     = ($urandom_range(0, 1) == 1);
            bus.id_uses_hilo   = ($urandom_range(0, 2) == 0);
            bus.branch_taken   = ($urandom_range(0, 2) == 0);
            bus.mdu_start      = (m_mdu == 0) && ($urandom_range(0, 4) == 0);
            bus.mem_busy       = ($urandom_range(0, 5) == 0);
            bus.EX_MEM_ExcCode = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            bus.eret_id        = ($urandom_range(0, 3) == 0);
            #1;
            n_cmp++;
            if (outs !== model_out()) begin
                n_err++; $display("FAIL random%0d: got %b want %b", i, outs, model_out());
            end
            cycle_end();
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        model_reset();
        test_reset();
        test_load_use();
        test_mdu();
        test_exception();
        test_eret();
        test_freeze();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
